// File: rtl/hs_word_aligner_deser.sv
// -----------------------------------------------------------------------------
// hs_word_aligner_deser
//   HS symbol deserializer with word alignment for the C-PHY slave RX path.
//   Collects 3-bit symbols {Flip,Rotation,Polarity} LSB-first into words of
//   SYM_PER_WORD symbols. With ALIGN_EN=1 the block hunts for the sync word to
//   set the word boundary; with ALIGN_EN=0 framing starts at the first enabled
//   symbol. Sits between the symbol decoder and the word-clock packet logic.
//
// Ports
//   RxSymClkHS  in   1             symbol clock, rising edge
//   RstN        in   1             async active-low reset
//   HSDeserEn   in   1             symbol sampling enable
//   SerSym      in   3             {Flip,Rotation,Polarity} of current symbol
//   RxPolarity  out  SYM_PER_WORD  bit k = SerSym[0] of symbol k of last word
//   RxRotation  out  SYM_PER_WORD  bit k = SerSym[1] of symbol k
//   RxFlip      out  SYM_PER_WORD  bit k = SerSym[2] of symbol k
//   WordValid   out  1             1-cycle pulse: new data word on outputs
//   SyncDet     out  1             1-cycle pulse: sync word detected
//   Locked      out  1             word boundary established
// -----------------------------------------------------------------------------
module hs_word_aligner_deser #(
  parameter int unsigned                   SYM_PER_WORD = 7,
  parameter bit                            ALIGN_EN     = 1'b1,
  parameter logic [3*SYM_PER_WORD-1:0]     SYNC_PATTERN = 21'b011_100_100_100_100_100_011,
  parameter logic [3*SYM_PER_WORD-1:0]     SYNC_MASK    = 21'b111_100_100_100_100_100_111
) (
  input  logic                    RxSymClkHS,
  input  logic                    RstN,
  input  logic                    HSDeserEn,
  input  logic [2:0]              SerSym,
  output logic [SYM_PER_WORD-1:0] RxPolarity,
  output logic [SYM_PER_WORD-1:0] RxRotation,
  output logic [SYM_PER_WORD-1:0] RxFlip,
  output logic                    WordValid,
  output logic                    SyncDet,
  output logic                    Locked
);

  localparam int unsigned W  = 3 * SYM_PER_WORD;
  localparam int unsigned CW = $clog2(SYM_PER_WORD);
  localparam logic [CW-1:0] LAST_SYM = CW'(SYM_PER_WORD - 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_HUNT   = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;

  logic [1:0]              state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;       // SymCnt; in HUNT it saturates as a fill count
  logic [W-1:0]            hist_q, hist_d;     // last symbols, newest at the top
  logic [SYM_PER_WORD-1:0] pol_q, pol_d;
  logic [SYM_PER_WORD-1:0] rot_q, rot_d;
  logic [SYM_PER_WORD-1:0] flip_q, flip_d;
  logic                    word_valid_q, word_valid_d;
  logic                    sync_det_q, sync_det_d;

  logic [W-1:0]            window;
  logic                    sync_hit;
  logic [1:0]              eff_state;
  logic [SYM_PER_WORD-1:0] win_pol, win_rot, win_flip;

  // The current symbol enters at the top so that after SYM_PER_WORD shifts
  // symbol 0 of the word sits in bits [2:0], matching SYNC_PATTERN layout.
  assign window   = {SerSym, hist_q[W-1:3]};
  assign sync_hit = ((window ^ SYNC_PATTERN) & SYNC_MASK) == '0;

  // IDLE forwards its first enabled symbol straight into the target state;
  // counters and history are already zero there.
  assign eff_state = (state_q == ST_IDLE) ? (ALIGN_EN ? ST_HUNT : ST_LOCKED) : state_q;

  always_comb begin
    for (int k = 0; k < int'(SYM_PER_WORD); k++) begin
      win_pol[k]  = window[3*k];
      win_rot[k]  = window[3*k+1];
      win_flip[k] = window[3*k+2];
    end
  end

  // NOTE: every signal driven here gets a default first, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    hist_d       = hist_q;
    pol_d        = pol_q;
    rot_d        = rot_q;
    flip_d       = flip_q;
    word_valid_d = 1'b0;
    sync_det_d   = 1'b0;

    if (!HSDeserEn) begin
      // Drop the partial word and match history; completed word stays visible.
      state_d = ST_IDLE;
      cnt_d   = '0;
      hist_d  = '0;
    end else begin
      hist_d  = window;
      state_d = eff_state;
      case (eff_state)
        ST_HUNT: begin
          if (cnt_q == LAST_SYM && sync_hit) begin
            state_d    = ST_LOCKED;
            cnt_d      = '0;
            sync_det_d = 1'b1;
          end else if (cnt_q != LAST_SYM) begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_LOCKED: begin
          if (cnt_q == LAST_SYM) begin
            cnt_d = '0;
            if (sync_hit) begin
              sync_det_d = 1'b1;
            end else begin
              word_valid_d = 1'b1;
              pol_d        = win_pol;
              rot_d        = win_rot;
              flip_d       = win_flip;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the values from before the edge, independent of statement order.
  always_ff @(posedge RxSymClkHS or negedge RstN) begin
    if (!RstN) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      hist_q       <= '0;
      pol_q        <= '0;
      rot_q        <= '0;
      flip_q       <= '0;
      word_valid_q <= 1'b0;
      sync_det_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      hist_q       <= hist_d;
      pol_q        <= pol_d;
      rot_q        <= rot_d;
      flip_q       <= flip_d;
      word_valid_q <= word_valid_d;
      sync_det_q   <= sync_det_d;
    end
  end

  assign RxPolarity = pol_q;
  assign RxRotation = rot_q;
  assign RxFlip     = flip_q;
  assign WordValid  = word_valid_q;
  assign SyncDet    = sync_det_q;
  assign Locked     = (state_q == ST_LOCKED);

endmodule

// File: tb/tb_hs_word_aligner_deser.sv
// -----------------------------------------------------------------------------
// tb_hs_word_aligner_deser
//   Directed bench for hs_word_aligner_deser. Instance u_free runs with
//   ALIGN_EN=0, instance u_align with ALIGN_EN=1; both share clock, reset and
//   symbol input but have separate enables.
// -----------------------------------------------------------------------------
module tb_hs_word_aligner_deser;

  localparam int N = 7;

  logic         clk;
  logic         rst_n;
  logic         en_a, en_b;
  logic [2:0]   sym;

  logic [N-1:0] pol_a, rot_a, flip_a, pol_b, rot_b, flip_b;
  logic         wv_a, sd_a, lk_a, wv_b, sd_b, lk_b;

  int n_checks = 0;
  int n_fail   = 0;

  logic [2:0] w2   [N] = '{3'b011, 3'b101, 3'b110, 3'b000, 3'b011, 3'b101, 3'b110};
  logic [2:0] sync [N] = '{3'b011, 3'b100, 3'b100, 3'b100, 3'b100, 3'b100, 3'b011};

  hs_word_aligner_deser #(.SYM_PER_WORD(N), .ALIGN_EN(1'b0)) u_free (
    .RxSymClkHS (clk),
    .RstN       (rst_n),
    .HSDeserEn  (en_a),
    .SerSym     (sym),
    .RxPolarity (pol_a),
    .RxRotation (rot_a),
    .RxFlip     (flip_a),
    .WordValid  (wv_a),
    .SyncDet    (sd_a),
    .Locked     (lk_a)
  );

  hs_word_aligner_deser #(.SYM_PER_WORD(N), .ALIGN_EN(1'b1)) u_align (
    .RxSymClkHS (clk),
    .RstN       (rst_n),
    .HSDeserEn  (en_b),
    .SerSym     (sym),
    .RxPolarity (pol_b),
    .RxRotation (rot_b),
    .RxFlip     (flip_b),
    .WordValid  (wv_b),
    .SyncDet    (sd_b),
    .Locked     (lk_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive on the falling edge, let the rising edge sample, look 1 ns later.
  task automatic step(input logic ea, input logic eb, input logic [2:0] s);
    @(negedge clk);
    en_a = ea;
    en_b = eb;
    sym  = s;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int wv_first, wv_second, wv_count;

    rst_n = 1'b0;
    en_a  = 1'b0;
    en_b  = 1'b0;
    sym   = 3'b000;

    // 1: reset
    repeat (5) @(posedge clk);
    #1;
    check("rst_pol_a",  16'(pol_a), 16'h0);
    check("rst_flags_a", {13'd0, wv_a, sd_a, lk_a}, 16'h0);
    check("rst_pol_b",  16'(pol_b), 16'h0);
    check("rst_flags_b", {13'd0, wv_b, sd_b, lk_b}, 16'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // 2: free-running framing, one word
    for (int k = 0; k < N; k++) begin
      step(1'b1, 1'b0, w2[k]);
      check("t2_locked", 16'(lk_a), 16'h1);
      check("t2_wv", 16'(wv_a), (k == N - 1) ? 16'h1 : 16'h0);
    end
    check("t2_pol",  16'(pol_a),  16'b0110011);
    check("t2_rot",  16'(rot_a),  16'b1010101);
    check("t2_flip", 16'(flip_a), 16'b1100110);
    step(1'b0, 1'b0, 3'b000);
    check("t2_wv_off", 16'(wv_a), 16'h0);
    check("t2_unlock", 16'(lk_a), 16'h0);
    check("t2_hold",   16'(pol_a), 16'b0110011);

    // 3: sync hunt, then data
    step(1'b0, 1'b1, 3'b111);
    step(1'b0, 1'b1, 3'b000);
    check("t3_hunt_lk", 16'(lk_b), 16'h0);
    for (int k = 0; k < N; k++) begin
      step(1'b0, 1'b1, sync[k]);
      check("t3_sd", 16'(sd_b), (k == N - 1) ? 16'h1 : 16'h0);
      check("t3_wv_none", 16'(wv_b), 16'h0);
    end
    check("t3_locked", 16'(lk_b), 16'h1);
    for (int k = 0; k < N; k++) begin
      step(1'b0, 1'b1, w2[k]);
      check("t3_wv", 16'(wv_b), (k == N - 1) ? 16'h1 : 16'h0);
    end
    check("t3_pol",  16'(pol_b),  16'b0110011);
    check("t3_rot",  16'(rot_b),  16'b1010101);
    check("t3_flip", 16'(flip_b), 16'b1100110);

    // 4: back-to-back words
    wv_first  = -1;
    wv_second = -1;
    wv_count  = 0;
    for (int i = 0; i < 2 * N; i++) begin
      step(1'b0, 1'b1, (i < N) ? w2[i] : 3'b101);
      check("t4_no_sd", 16'(sd_b), 16'h0);
      if (wv_b === 1'b1) begin
        wv_count++;
        if (wv_first < 0) wv_first = i;
        else              wv_second = i;
      end
    end
    check("t4_count", 16'(wv_count), 16'd2);
    check("t4_gap",   16'(wv_second - wv_first), 16'd7);
    check("t4_pol",   16'(pol_b),  16'b1111111);
    check("t4_rot",   16'(rot_b),  16'b0000000);
    check("t4_flip",  16'(flip_b), 16'b1111111);

    // 4b: aligned sync while locked -> SyncDet only, outputs hold
    for (int k = 0; k < N; k++) begin
      step(1'b0, 1'b1, sync[k]);
      check("t4s_wv", 16'(wv_b), 16'h0);
    end
    check("t4s_sd",   16'(sd_b),  16'h1);
    check("t4s_hold", 16'(pol_b), 16'b1111111);

    // 5: disable mid-word
    for (int k = 0; k < 4; k++) step(1'b0, 1'b1, w2[k]);
    step(1'b0, 1'b0, 3'b000);
    check("t5_wv",     16'(wv_b), 16'h0);
    check("t5_unlock", 16'(lk_b), 16'h0);
    check("t5_hold",   16'(flip_b), 16'b1111111);
    for (int k = 0; k < N; k++) begin
      step(1'b0, 1'b1, w2[k]);
      check("t5_nodata_wv", 16'(wv_b), 16'h0);
      check("t5_nodata_sd", 16'(sd_b), 16'h0);
    end
    check("t5_still_unlocked", 16'(lk_b), 16'h0);
    for (int k = 0; k < N; k++) begin
      step(1'b0, 1'b1, sync[k]);
      check("t5_resync", 16'(sd_b), (k == N - 1) ? 16'h1 : 16'h0);
    end
    for (int k = 0; k < N; k++) step(1'b0, 1'b1, w2[k]);
    check("t5_wv_after", 16'(wv_b), 16'h1);
    check("t5_rot",      16'(rot_b), 16'b1010101);

    // 6: async reset mid-word while locked
    for (int k = 0; k < 3; k++) step(1'b0, 1'b1, w2[k]);
    check("t6_locked", 16'(lk_b), 16'h1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_pol",   16'(pol_b),  16'h0);
    check("t6_flip",  16'(flip_b), 16'h0);
    check("t6_flags", {13'd0, wv_b, sd_b, lk_b}, 16'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 3; k < N; k++) begin
      step(1'b0, 1'b1, w2[k]);
      check("t6_no_wv", 16'(wv_b), 16'h0);
    end
    check("t6_pol_zero", 16'(pol_b), 16'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
